// File: rtl/ola_pkg.sv
// Shared constants, FSM state type and fixed-point helpers
// for the overlap-add synthesis block.
package ola_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_N_FFT   = 512;
    localparam int DEF_WIN_LEN = 480;
    localparam int DEF_HOP_LEN = 160;

    localparam int OFF   = (DEF_N_FFT - DEF_WIN_LEN) / 2;
    localparam int ACC_W = DEF_WIDTH + 2;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    function automatic int win_off(input int n, input int win);
        return (n - win) / 2;
    endfunction

    function automatic bit params_ok(input int n, input int win, input int hop);
        return (hop > 0) && (win <= n) && (((n - win) % 2) == 0) &&
               ((win % hop) == 0);
    endfunction

    function automatic logic signed [31:0] round_q15(
        input logic signed [31:0] prod
    );
        return (prod + 32'sd16384) >>> 15;
    endfunction

    function automatic logic signed [31:0] sat_w(
        input logic signed [31:0] v,
        input int                 w
    );
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Periodic Hann coefficient; 1.0 is clamped to the largest positive code
    function automatic int hann_q(input int j, input int len, input int w);
        real v;
        real s;
        int  full;
        full = (1 << (w - 1)) - 1;
        v = 0.5 - 0.5 * $cos(6.283185307179586 * real'(j) / real'(len));
        s = $floor(v * real'(full + 1) + 0.5);
        if (s > real'(full)) return full;
        return $rtoi(s);
    endfunction

endpackage

// File: rtl/ola_win_rom.sv
// Synchronous periodic-Hann synthesis window ROM, one-cycle read.
module ola_win_rom
    import ola_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int WIN_LEN = DEF_WIN_LEN,
    localparam int AW     = $clog2(WIN_LEN)
) (
    input  logic                    clk,
    input  logic [AW-1:0]           addr,
    output logic signed [WIDTH-1:0] q
);

    logic signed [WIDTH-1:0] rom [WIN_LEN];

    for (genvar i = 0; i < WIN_LEN; i++) begin : g_rom
        assign rom[i] = WIDTH'(hann_q(i, WIN_LEN, WIDTH));
    end

    always_ff @(posedge clk) begin
        q <= rom[addr];
    end

endmodule

// File: rtl/ola_synth.sv
// Streaming inverse-STFT overlap-add: windows IFFT frames and sums
// them HOP_LEN apart, emitting HOP_LEN finished samples per frame.
module ola_synth
    import ola_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int N_FFT   = DEF_N_FFT,
    parameter int WIN_LEN = DEF_WIN_LEN,
    parameter int HOP_LEN = DEF_HOP_LEN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    den,
    input  logic signed [WIDTH-1:0] din_re,
    input  logic signed [WIDTH-1:0] din_im,
    output logic                    din_rdy,
    output logic                    dout_en,
    output logic signed [WIDTH-1:0] dout_re
);

    localparam int OFS = win_off(N_FFT, WIN_LEN);
    localparam int ACW = WIDTH + 2;
    localparam int KW  = $clog2(N_FFT);
    localparam int AW  = $clog2(WIN_LEN);

    if (!params_ok(N_FFT, WIN_LEN, HOP_LEN)) begin : g_bad_params
        $error("ola_synth: illegal N_FFT/WIN_LEN/HOP_LEN combination");
    end

    logic unused_im;
    assign unused_im = ^din_im;

    state_t        state;
    logic [AW-1:0] clr_addr;
    logic [KW-1:0] k;
    logic [AW-1:0] base;
    logic          accept;

    logic [KW-1:0] j_c;
    logic [AW:0]   sum_c;
    logic [AW:0]   nb_c;
    logic [AW-1:0] addr_c;
    logic [AW-1:0] next_base;
    logic          in_win;
    logic          in_out;

    assign accept = den & din_rdy;
    assign j_c    = k - KW'(OFS);
    assign in_win = (k >= KW'(OFS)) &&
                    ({1'b0, k} < (KW+1)'(OFS + WIN_LEN));
    assign in_out = j_c < KW'(HOP_LEN);

    // Circular accumulator: base advances one hop per frame
    assign sum_c  = {1'b0, base} + (AW+1)'(j_c);
    assign addr_c = (sum_c >= (AW+1)'(WIN_LEN)) ?
                    AW'(sum_c - (AW+1)'(WIN_LEN)) : sum_c[AW-1:0];
    assign nb_c      = {1'b0, base} + (AW+1)'(HOP_LEN);
    assign next_base = (nb_c >= (AW+1)'(WIN_LEN)) ?
                       AW'(nb_c - (AW+1)'(WIN_LEN)) : nb_c[AW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
            din_rdy  <= 1'b0;
            k        <= '0;
            base     <= '0;
        end else begin
            unique case (state)
                CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == AW'(WIN_LEN - 1)) begin
                        state   <= RUN;
                        din_rdy <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (k == KW'(N_FFT - 1)) begin
                            k    <= '0;
                            base <= next_base;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    logic                      v1, v2, v3;
    logic                      o1, o2, o3;
    logic [AW-1:0]             a1, a2, a3;
    logic [AW-1:0]             j1;
    logic signed [WIDTH-1:0]   x1, x2;
    logic signed [WIDTH-1:0]   w2;
    logic signed [ACW-1:0]     rd2, acc3;
    logic signed [2*WIDTH-1:0] prod3;
    logic signed [31:0]        tot_c;

    ola_win_rom #(
        .WIDTH   (WIDTH),
        .WIN_LEN (WIN_LEN)
    ) u_rom (
        .clk  (clk),
        .addr (j1),
        .q    (w2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            o1      <= 1'b0;
            o2      <= 1'b0;
            o3      <= 1'b0;
            a1      <= '0;
            a2      <= '0;
            a3      <= '0;
            j1      <= '0;
            x1      <= '0;
            x2      <= '0;
            acc3    <= '0;
            prod3   <= '0;
            dout_en <= 1'b0;
            dout_re <= '0;
        end else begin
            v1      <= accept & in_win;
            o1      <= in_out;
            a1      <= addr_c;
            j1      <= AW'(j_c);
            x1      <= din_re;
            v2      <= v1;
            o2      <= o1;
            a2      <= a1;
            x2      <= x1;
            v3      <= v2;
            o3      <= o2;
            a3      <= a2;
            acc3    <= rd2;
            prod3   <= (2*WIDTH)'(x2) * (2*WIDTH)'(w2);
            dout_en <= v3 & o3;
            if (v3 && o3) begin
                dout_re <= WIDTH'(sat_w(tot_c, WIDTH));
            end
        end
    end

    assign tot_c = 32'(acc3) + round_q15(32'(prod3));

    logic signed [ACW-1:0] acc [WIN_LEN];
    logic                  we;
    logic [AW-1:0]         wa;
    logic signed [ACW-1:0] wd;

    // Finished entries are zeroed so the slot is fresh for the next frame
    always_comb begin
        we = 1'b0;
        wa = a3;
        wd = '0;
        if (state == CLEAR) begin
            we = 1'b1;
            wa = clr_addr;
        end else if (v3) begin
            we = 1'b1;
            wd = o3 ? '0 : ACW'(tot_c);
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            acc[wa] <= wd;
        end
        rd2 <= acc[a1];
    end

endmodule

// File: tb/tb_ola_synth.sv
// Scoreboard bench for ola_synth: a frame-history model predicts
// every output value and the cycle it must appear on.
module tb_ola_synth;

    localparam int WIDTH   = 16;
    localparam int N_FFT   = 512;
    localparam int WIN_LEN = 480;
    localparam int HOP_LEN = 160;
    localparam int OFF     = 16;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    den = 1'b0;
    logic signed [WIDTH-1:0] din_re = '0;
    logic signed [WIDTH-1:0] din_im = '0;
    logic                    din_rdy;
    logic                    dout_en;
    logic signed [WIDTH-1:0] dout_re;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int out_cnt = 0;
    int last_out = 0;
    int nfr = 0;
    int exp_q[$];
    int tim_q[$];
    int cur[N_FFT];
    int prev1[N_FFT];
    int prev2[N_FFT];
    int wtab[WIN_LEN];

    ola_synth dut (
        .clk     (clk),
        .rst     (rst),
        .den     (den),
        .din_re  (din_re),
        .din_im  (din_im),
        .din_rdy (din_rdy),
        .dout_en (dout_en),
        .dout_re (dout_re)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int hann(int j);
        real v;
        real s;
        v = 0.5 - 0.5 * $cos(2.0 * 3.141592653589793 * real'(j) / 480.0);
        s = $floor(v * 32768.0 + 0.5);
        if (s > 32767.0) s = 32767.0;
        return $rtoi(s);
    endfunction

    function automatic int pr(int x, int j);
        int p;
        p = x * wtab[j];
        return (p + 16384) >>> 15;
    endfunction

    function automatic int sat16(int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic monitor();
        int e;
        int t;
        forever begin
            @(negedge clk);
            if (dout_en === 1'b1) begin
                out_cnt++;
                last_out = int'(dout_re);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_out got %0d expected no output",
                             int'(dout_re));
                end else begin
                    e = exp_q.pop_front();
                    t = tim_q.pop_front();
                    if (int'(dout_re) !== e) begin
                        errors++;
                        $display("FAIL out_value got %0d expected %0d",
                                 int'(dout_re), e);
                    end
                    checks++;
                    if (cyc !== t) begin
                        errors++;
                        $display("FAIL out_latency got cycle %0d expected %0d",
                                 cyc, t);
                    end
                end
            end
        end
    endtask

    task automatic drive_frame(input int mode, input int val,
                               input bit gaps, input int nsamp);
        logic signed [WIDTH-1:0] r;
        int j;
        int e;
        for (int k = 0; k < N_FFT; k++) begin
            r = WIDTH'($urandom);
            cur[k] = (mode == 0) ? val : int'(r);
        end
        for (int k = 0; k < nsamp; k++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    den = 1'b0;
                    din_re = WIDTH'($urandom);
                end
            end
            @(negedge clk);
            den = 1'b1;
            din_re = WIDTH'(cur[k]);
            din_im = WIDTH'($urandom);
            if (k >= OFF && k < OFF + HOP_LEN) begin
                j = k - OFF;
                e = pr(cur[k], j);
                if (nfr >= 1) e += pr(prev1[k + HOP_LEN], j + HOP_LEN);
                if (nfr >= 2) e += pr(prev2[k + 2*HOP_LEN], j + 2*HOP_LEN);
                exp_q.push_back(sat16(e));
                tim_q.push_back(cyc + 4);
            end
        end
        if (nsamp == N_FFT) begin
            prev2 = prev1;
            prev1 = cur;
            nfr++;
        end
    endtask

    task automatic drain(input string name, input int want_outs);
        @(negedge clk);
        den = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending got %0d outstanding expected 0",
                     name, exp_q.size());
        end
        checks++;
        if (out_cnt != want_outs) begin
            errors++;
            $display("FAIL %s_count got %0d outputs expected %0d",
                     name, out_cnt, want_outs);
        end
        exp_q.delete();
        tim_q.delete();
    endtask

    task automatic do_reset();
        int n;
        @(negedge clk);
        rst = 1'b1;
        den = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        tim_q.delete();
        nfr = 0;
        out_cnt = 0;
        rst = 1'b0;
        n = 0;
        while (din_rdy !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (din_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_timeout got %b expected 1", din_rdy);
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        den = 1'b1;
        din_re = 16'sh7FFF;
        repeat (3) @(negedge clk);
        checks++;
        if (dout_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_dout_en got %b expected 0", dout_en);
        end
        checks++;
        if (dout_re !== '0) begin
            errors++;
            $display("FAIL rst_dout_re got %h expected 0000", dout_re);
        end
        checks++;
        if (din_rdy !== 1'b0) begin
            errors++;
            $display("FAIL rst_din_rdy got %b expected 0", din_rdy);
        end
        rst = 1'b0;
        n = 0;
        while (din_rdy !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        den = 1'b0;
        checks++;
        if (n != WIN_LEN) begin
            errors++;
            $display("FAIL clear_len got %0d cycles expected %0d", n, WIN_LEN);
        end
    endtask

    task automatic test_zero_frame();
        out_cnt = 0;
        drive_frame(0, 0, 1'b0, N_FFT);
        drain("zero_frame", HOP_LEN);
    endtask

    task automatic test_const_half();
        do_reset();
        for (int f = 0; f < 4; f++) drive_frame(0, 16384, 1'b0, N_FFT);
        drain("const_half", 4*HOP_LEN);
    endtask

    task automatic test_saturation();
        do_reset();
        for (int f = 0; f < 4; f++) drive_frame(0, 32767, 1'b0, N_FFT);
        drain("sat_pos", 4*HOP_LEN);
        checks++;
        if (last_out != 32767) begin
            errors++;
            $display("FAIL sat_pos_last got %0d expected 32767", last_out);
        end
        out_cnt = 0;
        for (int f = 0; f < 4; f++) drive_frame(0, -32768, 1'b0, N_FFT);
        drain("sat_neg", 4*HOP_LEN);
        checks++;
        if (last_out != -32768) begin
            errors++;
            $display("FAIL sat_neg_last got %0d expected -32768", last_out);
        end
    endtask

    task automatic test_random_gaps();
        do_reset();
        for (int f = 0; f < 4; f++) drive_frame(1, 0, 1'b1, N_FFT);
        drain("random_gaps", 4*HOP_LEN);
    endtask

    task automatic test_mid_reset();
        int n;
        do_reset();
        for (int f = 0; f < 3; f++) drive_frame(0, 16384, 1'b0, N_FFT);
        drive_frame(0, 16384, 1'b0, 201);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (dout_en !== 1'b0 || dout_re !== '0) begin
            errors++;
            $display("FAIL midrst_out got en=%b re=%h expected en=0 re=0000",
                     dout_en, dout_re);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL midrst_pending got %0d expected 0", exp_q.size());
        end
        den = 1'b0;
        exp_q.delete();
        tim_q.delete();
        nfr = 0;
        out_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (din_rdy !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != WIN_LEN) begin
            errors++;
            $display("FAIL midrst_clear got %0d cycles expected %0d",
                     n, WIN_LEN);
        end
        drive_frame(0, 16384, 1'b0, N_FFT);
        drain("midrst_frame0", HOP_LEN);
    endtask

    initial begin
        for (int j = 0; j < WIN_LEN; j++) wtab[j] = hann(j);
        fork
            monitor();
        join_none
        test_reset();
        test_zero_frame();
        test_const_half();
        test_saturation();
        test_random_gaps();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
